// File: rtl/rom_pkg.sv
// Shared widths, FSM state encoding and line-index extraction for the ROM line server.
package rom_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Line index is byte address bits [idx_w+3:4]; caller truncates the result to idx_w bits.
  function automatic logic [31:0] line_index(input logic [31:0] addr, input int unsigned idx_w);
    return (addr >> 4) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_line_array.sv
// Line storage: synchronous 128-bit line read, 32-bit lane write, old data returned on collision.
module rom_line_array
  import rom_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [31:0]       wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];
  logic [LINE_W-1:0] rd_data_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        wr_lane;
  logic              unused_byte_bits;

  assign wr_idx           = IDX_W'(line_index(wr_addr_i, IDX_W));
  assign wr_lane          = wr_addr_i[3:2];
  assign unused_byte_bits = ^wr_addr_i[1:0];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wr_idx][wr_lane*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

  // Nonblocking read sees the pre-write contents when both hit the same line on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rom_line_server.sv
// Instruction-ROM responder: latches a line request, waits LATENCY cycles, returns the line with a ready pulse.
module rom_line_server
  import rom_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       rom_addr_i,
  input  logic              rom_valid_req_i,
  output logic              rom_ready_o,
  output logic [LINE_W-1:0] rom_data_o,
  input  logic              load_we_i,
  input  logic [31:0]       load_addr_i,
  input  logic [WORD_W-1:0] load_data_i,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, req_idx, rd_idx;
  logic             ready_q, busy_q;
  logic             req_take, rd_en;

  assign req_idx  = IDX_W'(line_index(rom_addr_i, IDX_W));
  assign req_take = (state_q == ST_IDLE) && rom_valid_req_i;
  assign cnt_d    = cnt_q - CNT_W'(1);

  // With a single-cycle latency the array is read straight from the incoming request.
  assign rd_en  = (LATENCY == 1) ? req_take : ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
  assign rd_idx = (LATENCY == 1) ? req_idx : idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rom_valid_req_i) begin
            idx_q  <= req_idx;
            busy_q <= 1'b1;
            if (LATENCY == 1) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  rom_line_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en_i  (rd_en),
    .rd_idx_i (rd_idx),
    .rd_data_o(rom_data_o),
    .we_i     (load_we_i),
    .wr_addr_i(load_addr_i),
    .wr_data_i(load_data_i)
  );

  assign rom_ready_o = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rom_line_server.sv
// Directed bench for rom_line_server: a LATENCY=4 instance and a LATENCY=1 instance sharing the load port.
module tb_rom_line_server;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_we;
  logic [31:0]  load_addr;
  logic [31:0]  load_data;

  logic [31:0]  addr_a, addr_b;
  logic         req_a, req_b;
  logic         ready_a, ready_b;
  logic [127:0] data_a, data_b;
  logic         busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE0   = 128'h00308193_00200113_00100093_00000013;
  localparam logic [127:0] LINE1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE2   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LINE2_W = 128'hAAAA0003_AAAA0002_DEADBEEF_AAAA0000;
  localparam logic [127:0] LINE3   = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;

  always #5 clk = ~clk;

  rom_line_server #(.DEPTH_LINES(256), .LATENCY(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr_i     (addr_a),
    .rom_valid_req_i(req_a),
    .rom_ready_o    (ready_a),
    .rom_data_o     (data_a),
    .load_we_i      (load_we),
    .load_addr_i    (load_addr),
    .load_data_i    (load_data),
    .busy_o         (busy_a)
  );

  rom_line_server #(.DEPTH_LINES(256), .LATENCY(1)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr_i     (addr_b),
    .rom_valid_req_i(req_b),
    .rom_ready_o    (ready_b),
    .rom_data_o     (data_b),
    .load_we_i      (load_we),
    .load_addr_i    (load_addr),
    .load_data_i    (load_data),
    .busy_o         (busy_b)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_we   = 1'b0;
  endtask

  // Pulse a request on the LATENCY=4 instance and check latency and returned line.
  task automatic fetch_a(input string tag, input logic [31:0] a, input logic [127:0] exp);
    int n;
    addr_a = a;
    req_a  = 1'b1;
    tick();
    req_a  = 1'b0;
    n = 1;
    while (!ready_a && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(4));
    chk({tag, "_data"}, data_a, exp);
    tick();
    chk({tag, "_rdy_drop"}, 128'(ready_a), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    addr_a = '0; addr_b = '0; req_a = 1'b0; req_b = 1'b0;
    #1;
    repeat (3) tick();
    chk("rst_ready", 128'(ready_a), 128'(0));
    chk("rst_data", data_a, 128'(0));
    chk("rst_busy", 128'(busy_a), 128'(0));
    chk("rst_ready1", 128'(ready_b), 128'(0));
    chk("rst_data1", data_b, 128'(0));
    rst_n = 1'b1;
    tick();

    write_word(32'h00, 32'h00000013); write_word(32'h04, 32'h00100093);
    write_word(32'h08, 32'h00200113); write_word(32'h0C, 32'h00308193);
    write_word(32'h10, 32'h11111111); write_word(32'h14, 32'h22222222);
    write_word(32'h18, 32'h33333333); write_word(32'h1C, 32'h44444444);
    write_word(32'h20, 32'hAAAA0000); write_word(32'h24, 32'hAAAA0001);
    write_word(32'h28, 32'hAAAA0002); write_word(32'h2C, 32'hAAAA0003);
    write_word(32'h30, 32'hC0DE0000); write_word(32'h34, 32'hC0DE0001);
    write_word(32'h38, 32'hC0DE0002); write_word(32'h3C, 32'hC0DE0003);
    chk("idle_busy", 128'(busy_a), 128'(0));

    fetch_a("basic", 32'h0000_0000, LINE0);
    fetch_a("alias", 32'h0000_100C, LINE0);
    fetch_a("line1", 32'h0000_1014, LINE1);

    // Held request: ready every 5 cycles, busy low only in IDLE cycles.
    addr_a = 32'h0000_0010;
    req_a  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("held_rdy%0d", i), 128'(ready_a), 128'((i % 5) == 3));
      chk($sformatf("held_busy%0d", i), 128'(busy_a), 128'((i % 5) != 4));
      if ((i % 5) == 3) chk($sformatf("held_data%0d", i), data_a, LINE1);
    end
    req_a = 1'b0;

    // LATENCY=1 instance: held request on line 3 served every other cycle.
    addr_b = 32'h0000_0030;
    req_b  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("l1_rdy%0d", i), 128'(ready_b), 128'((i % 2) == 0));
      chk($sformatf("l1_busy%0d", i), 128'(busy_b), 128'((i % 2) == 0));
      if ((i % 2) == 0) chk($sformatf("l1_data%0d", i), data_b, LINE3);
    end
    req_b = 1'b0;
    tick();

    // Reset two cycles after a request: in-flight request abandoned, no late ready.
    addr_a = 32'h0000_0000;
    req_a  = 1'b1;
    tick();
    req_a  = 1'b0;
    tick();
    rst_n  = 1'b0;
    tick();
    chk("mid_rst_ready", 128'(ready_a), 128'(0));
    chk("mid_rst_data", data_a, 128'(0));
    chk("mid_rst_busy", 128'(busy_a), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_rdy%0d", i), 128'(ready_a), 128'(0));
    end

    // Write one cycle before the read edge: new word is returned.
    addr_a = 32'h0000_0020;
    req_a  = 1'b1;
    tick();
    req_a  = 1'b0;
    tick();
    write_word(32'h24, 32'hDEADBEEF);
    tick();
    chk("coll_early_rdy", 128'(ready_a), 128'(1));
    chk("coll_early_data", data_a, LINE2_W);
    tick();

    // Write on the read edge: old word is returned, new word lands in the array.
    write_word(32'h24, 32'hAAAA0001);
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    tick();
    tick();
    write_word(32'h24, 32'hDEADBEEF);
    chk("coll_edge_rdy", 128'(ready_a), 128'(1));
    chk("coll_edge_data", data_a, LINE2);
    tick();
    fetch_a("coll_after", 32'h0000_0020, LINE2_W);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_line_server.md
# rom_line_server

Instruction-ROM responder that sits on the far side of the core's line-fill interface and answers the ICache's miss requests. It accepts a 32-bit byte address with a valid request, waits a programmable number of cycles, then returns the addressed 128-bit cache line with a one-cycle ready pulse. Contents are preloaded through a 32-bit word write port, either by the testbench or by a boot loader. It serves as the simulation and FPGA memory model for the core's fetch path.

## Interface

- `DEPTH_LINES`, default 256: number of 128-bit lines. Power of two, at least 2.
- `LATENCY`, default 4: cycles from request sample to ready pulse. At least 1.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `rom_addr_i`, input, 32: byte address from the core (`rv32core_addr_o`).
- `rom_valid_req_i`, input, 1: line request from the core (`rv32core_valid_req_o`).
- `rom_ready_o`, output, 1: one-cycle pulse; the line on `rom_data_o` is valid in that cycle.
- `rom_data_o`, output, 128: returned line.
- `load_we_i`, input, 1: preload word write enable.
- `load_addr_i`, input, 32: preload byte address. Word index is bits [IDX_W+3:2].
- `load_data_i`, input, 32: preload word.
- `busy_o`, output, 1: high while a request is in flight (WAIT or RESP).

## Operation

- Line index: IDX_W = log2(DEPTH_LINES), index = `rom_addr_i`[IDX_W+3:4].
  - Address bits [3:0] are ignored; requests are always line-aligned.
  - Bits above IDX_W+3 are ignored, so addresses alias modulo the array size.
- Lane order: `rom_data_o`[32k+31:32k] is word k of the line, k = 0..3. Word 0 is the lowest address.
- State machine:
  - IDLE: if `rom_valid_req_i` = 1, latch the index. Go to RESP if LATENCY = 1, otherwise load the counter with LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter. When the counter reaches 1, read the array into the data register and go to RESP. Inputs other than the load port are ignored.
  - RESP: `rom_ready_o` = 1 for exactly this cycle, then go to IDLE. `rom_valid_req_i` is ignored here, even if the requester has not yet dropped it.
- In the LATENCY = 1 case, the array read happens on the IDLE→RESP edge.
- Back-to-back requests: a request held high after RESP is sampled again in the following IDLE cycle and served as a new request. The requester must drop `rom_valid_req_i` in the cycle after the ready pulse unless it wants a repeat.
- `rom_data_o` holds the last returned line until the next response. It is not zeroed outside RESP.
- Load port:
  - Writes are accepted in any state.
  - A write on the same edge as the array read into the data register is not visible in that response (read-before-write).
  - A write earlier in WAIT is visible.
- The array is not cleared by reset. Contents are undefined until loaded.

## Timing

- Reset values: `rom_ready_o` = 0, `rom_data_o` = 0, `busy_o` = 0, state IDLE, counter 0.
- Latency: a request sampled high at edge t produces `rom_ready_o` = 1 in the cycle after edge t+LATENCY-1. That is exactly LATENCY edges after the sample, with the ready cycle counted as edge t+LATENCY.
- Throughput: one line every LATENCY+1 cycles with the request held continuously.
- Reset mid-operation: on the next edge with `rst_n` = 0, the machine returns to IDLE, drops ready, zeroes data and abandons the in-flight request. No ready pulse follows reset.
- Reset and request in the same cycle: reset wins and the request is not captured.
- The counter width is sized so that LATENCY-1 fits. It never wraps in normal operation.

## Structure

- Package `rom_pkg` holds:
  - LINE_W = 128 and WORD_W = 32.
  - The state enum (IDLE, WAIT, RESP).
  - The line-index extraction function.
- Sub-module `rom_line_array` holds the storage:
  - DEPTH_LINES × 128.
  - One synchronous 128-bit line read port.
  - One 32-bit word write port with a lane select from `load_addr_i`[3:2].
  - Read-before-write on address collision.
- The top level contains the FSM, the counter and the output registers.

## Test plan

1. **Basic fetch.** Preload words 0x00000013, 0x00100093, 0x00200113 and 0x00308193 at byte addresses 0x0–0xC. Pulse a request at 0x0. Expect ready exactly 4 cycles later with data = 0x00308193_00200113_00100093_00000013.
2. **Unaligned and aliasing addresses.** With DEPTH_LINES = 256, request 0x0000100C. Expect the line-0 data, because bits [3:0] are dropped and index bits [11:4] are 0.
3. **Held request.** Hold `rom_valid_req_i` high for 20 cycles. Expect ready pulses spaced 5 cycles apart, each one cycle wide, and `busy_o` low only in the IDLE cycles.
4. **LATENCY = 1 build.** Request line 3. Expect ready on the next cycle with line-3 data, and back-to-back service every 2 cycles.
5. **Reset mid-WAIT.** Assert `rst_n` = 0 two cycles after a request. Expect ready = 0, data = 0 and state IDLE after that edge, with no stale ready pulse after release.
6. **Load collision.** During WAIT, write 0xDEADBEEF to word 1 of the in-flight line:
   - one cycle before the read edge: expect it to be returned;
   - on the read edge: expect the old word to be returned.
